sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_pkg.sv | 39 +++
 rtl/melody_rom.sv | 28 ++
 rtl/sound_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_sound_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the win/lose sound sequencer.
//   - state_e  : sequencer FSM states
//   - mel_e    : melody selector
//   - pend_t   : one-deep pending-request slot
//   - WIN_TABLE / LOSE_TABLE : note tables, entry [0] plays first
package sound_pkg;

    localparam int unsigned CNT_W          = 26;
    localparam int unsigned TONE_W         = 4;
    localparam int unsigned TABLE_LEN      = 4;
    localparam int unsigned TAB_IDX_W      = 2;
    localparam int unsigned DEF_NOTE_TICKS = 12_500_000;
    localparam int unsigned DEF_GAP_TICKS  = 2_500_000;
    localparam int unsigned DEF_MELODY_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        WIN_MEL  = 1'b0,
        LOSE_MEL = 1'b1
    } mel_e;

    typedef logic [TONE_W-1:0] tone_t;

    typedef struct packed {
        logic valid;
        mel_e mel;
    } pend_t;

    // Rightmost element is note 0.
    localparam tone_t [TABLE_LEN-1:0] WIN_TABLE  = {4'd7, 4'd4, 4'd2, 4'd0};
    localparam tone_t [TABLE_LEN-1:0] LOSE_TABLE = {4'd0, 4'd3, 4'd5, 4'd7};

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup: (melody select, note index) -> tone index.
//   mel_sel_i  : WIN_MEL or LOSE_MEL
//   note_idx_i : position within the melody
//   tone_idx_o : tone generator index for that note
module melody_rom
    import sound_pkg::*;
#(
    parameter int unsigned IDX_W = 2
) (
    input  mel_e             mel_sel_i,
    input  logic [IDX_W-1:0] note_idx_i,
    output tone_t            tone_idx_o
);

    logic [TAB_IDX_W-1:0] tab_idx;

    // Tables hold four notes; the index is narrowed to the table range.
    always_comb begin
        tab_idx    = TAB_IDX_W'(note_idx_i);
        tone_idx_o = '0;
        if (mel_sel_i == LOSE_MEL) begin
            tone_idx_o = LOSE_TABLE[tab_idx];
        end else begin
            tone_idx_o = WIN_TABLE[tab_idx];
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Plays a short win or lose melody on request from the game FSM.
//   clk, resetN   : clock, synchronous active-low reset
//   win_req       : one-cycle request for the win melody
//   lose_req      : one-cycle request for the lose melody (has priority)
//   mute          : level, gates enable_sound only
//   tone_idx      : note index for the tone generator
//   enable_sound  : tone generator enable (sounding note and not muted)
//   busy          : sequencer not idle
//   done          : one-cycle pulse at the end of a completed melody
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
    parameter int unsigned MELODY_LEN = DEF_MELODY_LEN
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        win_req,
    input  logic        lose_req,
    input  logic        mute,
    output logic [3:0]  tone_idx,
    output logic        enable_sound,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W = (MELODY_LEN > 1) ? $clog2(MELODY_LEN) : 1;

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MELODY_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    mel_e               mel_q, mel_d;
    pend_t              pend_q, pend_d;

    tone_t              tone_idx_q, tone_idx_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    tone_t              rom_tone_c;
    logic               cnt_zero_c;
    logic               last_note_c;
    logic               pend_lose_c;

    // Lookup is done on the next-state note so the tone register lines up
    // with the state it belongs to.
    melody_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .mel_sel_i  (mel_d),
        .note_idx_i (idx_d),
        .tone_idx_o (rom_tone_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            mel_q      <= WIN_MEL;
            pend_q     <= '0;
            tone_idx_q <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mel_q      <= mel_d;
            pend_q     <= pend_d;
            tone_idx_q <= tone_idx_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state, tick counter, note index and pending-slot logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mel_d       = mel_q;
        pend_d      = pend_q;
        cnt_zero_c  = (cnt_q == '0);
        last_note_c = (idx_q == LAST_IDX);
        pend_lose_c = pend_q.valid && (pend_q.mel == LOSE_MEL);

        unique case (state_q)
            IDLE: begin
                if (win_req || lose_req) begin
                    state_d = PLAY;
                    cnt_d   = NOTE_LOAD;
                    idx_d   = '0;
                    mel_d   = lose_req ? LOSE_MEL : WIN_MEL;
                end
            end

            PLAY, GAP: begin
                if (lose_req && (mel_q == WIN_MEL)) begin
                    // Lose aborts a running win melody without a done pulse.
                    state_d = PLAY;
                    cnt_d   = NOTE_LOAD;
                    idx_d   = '0;
                    mel_d   = LOSE_MEL;
                end else begin
                    if (lose_req) begin
                        pend_d = '{valid: 1'b1, mel: LOSE_MEL};
                    end else if (win_req && !pend_lose_c) begin
                        pend_d = '{valid: 1'b1, mel: WIN_MEL};
                    end

                    if (!cnt_zero_c) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (state_q == PLAY) begin
                        if (last_note_c) begin
                            state_d = DONE;
                        end else begin
                            state_d = GAP;
                            cnt_d   = GAP_LOAD;
                        end
                    end else begin
                        state_d = PLAY;
                        cnt_d   = NOTE_LOAD;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end

            DONE: begin
                // A fresh request competes with the pending one; lose wins.
                if (lose_req || pend_lose_c) begin
                    state_d = PLAY;
                    cnt_d   = NOTE_LOAD;
                    idx_d   = '0;
                    mel_d   = LOSE_MEL;
                    pend_d  = '0;
                    if (win_req && !lose_req) begin
                        pend_d = '{valid: 1'b1, mel: WIN_MEL};
                    end
                end else if (win_req || pend_q.valid) begin
                    state_d = PLAY;
                    cnt_d   = NOTE_LOAD;
                    idx_d   = '0;
                    mel_d   = WIN_MEL;
                    pend_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        tone_idx_d = '0;
        enable_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (state_d != IDLE) begin
            tone_idx_d = rom_tone_c;
            busy_d     = 1'b1;
        end
        enable_d = (state_d == PLAY) && !mute;
        done_d   = (state_d == DONE);
    end

    assign tone_idx     = tone_idx_q;
    assign enable_sound = enable_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_TICKS=4, GAP_TICKS=2.
// Cycle c is the interval after the c-th clock edge following reset release;
// inputs are driven and outputs compared 1 time unit after that edge.
module tb_sound_sequencer;

    logic       clk;
    logic       resetN;
    logic       win_req;
    logic       lose_req;
    logic       mute;
    logic [3:0] tone_idx;
    logic       enable_sound;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    sound_sequencer #(
        .NOTE_TICKS (4),
        .GAP_TICKS  (2),
        .MELODY_LEN (4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .win_req      (win_req),
        .lose_req     (lose_req),
        .mute         (mute),
        .tone_idx     (tone_idx),
        .enable_sound (enable_sound),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int scen;
        int cyc;
        bit is_exp;   // 0: stimulus row, 1: expectation row
        bit win;
        bit lose;
        bit rstn;
        bit tchk;     // compare tone_idx
        int tone;
        bit en;
        bit bsy;
        bit dn;
    } vec_t;

    vec_t vecs[$];

    task automatic stim(input int s, input int c, input bit w, input bit l, input bit r);
        vec_t v;
        v = '{scen: s, cyc: c, is_exp: 1'b0, win: w, lose: l, rstn: r,
              tchk: 1'b0, tone: 0, en: 1'b0, bsy: 1'b0, dn: 1'b0};
        vecs.push_back(v);
    endtask

    task automatic expv(input int s, input int c, input int t, input bit e, input bit b);
        vec_t v;
        v = '{scen: s, cyc: c, is_exp: 1'b1, win: 1'b0, lose: 1'b0, rstn: 1'b1,
              tchk: 1'b1, tone: t, en: e, bsy: b, dn: 1'b0};
        vecs.push_back(v);
    endtask

    // End-of-melody cycle: done=1, busy=1, sound off; tone not compared.
    task automatic expd(input int s, input int c);
        vec_t v;
        v = '{scen: s, cyc: c, is_exp: 1'b1, win: 1'b0, lose: 1'b0, rstn: 1'b1,
              tchk: 1'b0, tone: 0, en: 1'b0, bsy: 1'b1, dn: 1'b1};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit m);
        resetN   = 1'b0;
        win_req  = 1'b0;
        lose_req = 1'b0;
        mute     = m;
        step();
        step();
        resetN = 1'b1;
    endtask

    task automatic run_scen(input int s, input int last, input bit m);
        bit found;
        do_reset(m);
        for (int c = 0; c <= last; c++) begin
            win_req  = 1'b0;
            lose_req = 1'b0;
            resetN   = 1'b1;
            found    = 1'b0;
            foreach (vecs[i]) begin
                if (vecs[i].scen == s && vecs[i].cyc == c) begin
                    if (!vecs[i].is_exp) begin
                        win_req  = vecs[i].win;
                        lose_req = vecs[i].lose;
                        resetN   = vecs[i].rstn;
                    end else begin
                        found = 1'b1;
                        if (vecs[i].tchk)
                            check($sformatf("s%0d c%0d tone", s, c), int'(tone_idx), vecs[i].tone);
                        check($sformatf("s%0d c%0d enable", s, c), int'(enable_sound), int'(vecs[i].en));
                        check($sformatf("s%0d c%0d busy", s, c), int'(busy), int'(vecs[i].bsy));
                        check($sformatf("s%0d c%0d done", s, c), int'(done), int'(vecs[i].dn));
                    end
                end
            end
            // done may only pulse where a row says so
            if (!found)
                check($sformatf("s%0d c%0d done-idle", s, c), int'(done), 0);
            step();
        end
    endtask

    // Full per-cycle waveform of the win melody from a small timing model.
    task automatic run_win_waveform();
        int win_tab[4];
        int note, ph, e_tone, e_en, e_busy, e_done;
        win_tab = '{0, 2, 4, 7};
        do_reset(1'b0);
        for (int c = 0; c <= 26; c++) begin
            win_req = (c == 0);
            note    = (c >= 1) ? (c - 1) / 6 : 0;
            ph      = (c >= 1) ? (c - 1) % 6 : 0;
            e_busy  = (c >= 1 && c <= 23) ? 1 : 0;
            e_done  = (c == 23) ? 1 : 0;
            e_en    = (c >= 1 && c <= 22 && ph < 4) ? 1 : 0;
            e_tone  = (c >= 1 && c <= 22) ? win_tab[note] : 0;
            if (c != 23)
                check($sformatf("wave c%0d tone", c), int'(tone_idx), e_tone);
            check($sformatf("wave c%0d enable", c), int'(enable_sound), e_en);
            check($sformatf("wave c%0d busy", c), int'(busy), e_busy);
            check($sformatf("wave c%0d done", c), int'(done), e_done);
            step();
        end
        win_req = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        resetN   = 1'b0;
        win_req  = 1'b0;
        lose_req = 1'b0;
        mute     = 1'b0;

        // 0: win melody timing
        stim(0, 0, 1, 0, 1);
        expv(0, 0, 0, 0, 0);
        expv(0, 1, 0, 1, 1);  expv(0, 4, 0, 1, 1);
        expv(0, 5, 0, 0, 1);  expv(0, 6, 0, 0, 1);
        expv(0, 7, 2, 1, 1);  expv(0, 10, 2, 1, 1); expv(0, 11, 2, 0, 1);
        expv(0, 13, 4, 1, 1); expv(0, 16, 4, 1, 1);
        expv(0, 19, 7, 1, 1); expv(0, 22, 7, 1, 1);
        expd(0, 23);
        expv(0, 24, 0, 0, 0);

        // 1: simultaneous requests -> lose only
        stim(1, 0, 1, 1, 1);
        expv(1, 1, 7, 1, 1);  expv(1, 7, 5, 1, 1);
        expv(1, 13, 3, 1, 1); expv(1, 19, 0, 1, 1);
        expd(1, 23);
        expv(1, 24, 0, 0, 0); expv(1, 30, 0, 0, 0);

        // 2: lose preempts win
        stim(2, 0, 1, 0, 1);
        stim(2, 8, 0, 1, 1);
        expv(2, 8, 2, 1, 1);
        expv(2, 9, 7, 1, 1);  expv(2, 12, 7, 1, 1); expv(2, 13, 7, 0, 1);
        expv(2, 15, 5, 1, 1); expv(2, 21, 3, 1, 1);
        expv(2, 27, 0, 1, 1); expv(2, 30, 0, 1, 1);
        expd(2, 31);
        expv(2, 32, 0, 0, 0);

        // 3: win pending behind lose, starts straight from DONE
        stim(3, 0, 0, 1, 1);
        stim(3, 3, 1, 0, 1);
        expv(3, 3, 7, 1, 1);  expv(3, 7, 5, 1, 1);
        expd(3, 23);
        expv(3, 24, 0, 1, 1); expv(3, 27, 0, 1, 1); expv(3, 28, 0, 0, 1);
        expv(3, 30, 2, 1, 1);
        expd(3, 46);
        expv(3, 47, 0, 0, 0); expv(3, 50, 0, 0, 0);

        // 4: muted win melody
        stim(4, 0, 1, 0, 1);
        expv(4, 1, 0, 0, 1);  expv(4, 7, 2, 0, 1);
        expv(4, 13, 4, 0, 1); expv(4, 19, 7, 0, 1); expv(4, 22, 7, 0, 1);
        expd(4, 23);
        expv(4, 24, 0, 0, 0);

        // 5: reset mid-melody, clean restart
        stim(5, 0, 1, 0, 1);
        stim(5, 10, 1, 1, 0);
        stim(5, 12, 1, 0, 1);
        expv(5, 7, 2, 1, 1);  expv(5, 10, 2, 1, 1);
        expv(5, 11, 0, 0, 0); expv(5, 12, 0, 0, 0);
        expv(5, 13, 0, 1, 1); expv(5, 16, 0, 1, 1); expv(5, 17, 0, 0, 1);
        expv(5, 19, 2, 1, 1);

        // 6: pending lose overwrites pending win, later win cannot replace it
        stim(6, 0, 0, 1, 1);
        stim(6, 2, 1, 0, 1);
        stim(6, 4, 0, 1, 1);
        stim(6, 6, 1, 0, 1);
        expd(6, 23);
        expv(6, 24, 7, 1, 1); expv(6, 30, 5, 1, 1);
        expd(6, 46);
        expv(6, 47, 0, 0, 0); expv(6, 50, 0, 0, 0);

        run_scen(0, 26, 1'b0);
        run_scen(1, 32, 1'b0);
        run_scen(2, 34, 1'b0);
        run_scen(3, 52, 1'b0);
        run_scen(4, 26, 1'b1);
        run_scen(5, 22, 1'b0);
        run_scen(6, 52, 1'b0);
        run_win_waveform();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
